seq_detector_param: RTL
=======================

Name: seq_detector_param

Overview:
Runtime-programmable serial pattern detector. It is the parametrised successor of the team's fixed-table serial-input FSMs. The pattern length is set by parameter. The pattern value and overlap mode are loaded at run time. A saturating match counter is included. It sits on a 1-bit serial stream with a per-bit valid qualifier, and feeds a match pulse plus match count to downstream control/status logic.

Parameters:
- PAT_W, 5, pattern length in bits (2..16)
- CNT_W, 8, match counter width (1..32)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- load  input  1  pulse; latch pat_in and mode_in, arm the detector
- pat_in  input  PAT_W  pattern; bit PAT_W-1 is the first (oldest) serial bit
- mode_in  input  1  1 = overlapping matches allowed; 0 = non-overlapping
- x  input  1  serial data bit
- x_valid  input  1  x is sampled on this edge when high
- cnt_clr  input  1  synchronous clear of match_count
- armed  output  1  pattern loaded, detector active
- match  output  1  registered one-cycle match pulse
- match_count  output  CNT_W  saturating count of matches since load/clear

Behaviour:
- Reset (rst=0, async):
  - pattern=0, mode=0, hist=0, fill=0, state=UNARMED.
  - Outputs: armed=0, match=0, match_count=0.
- States:
  - UNARMED: x_valid is ignored; match=0.
  - FILL: fill < PAT_W.
  - ARMED: fill == PAT_W.
- Transitions:
  - load from any state -> FILL.
  - FILL -> ARMED when the sampled bit makes fill reach PAT_W.
  - ARMED -> FILL after a match when mode=0.
  - Otherwise the state holds.
- Load cycle:
  - pattern<=pat_in, mode<=mode_in, hist<=0, fill<=0, match_count<=0, match<=0.
  - load has priority over x_valid and cnt_clr in the same cycle; the x bit is dropped.
- Sample (x_valid=1, not load, state != UNARMED):
  - hist_n = {hist[PAT_W-2:0], x}.
  - fill_n = min(fill+1, PAT_W).
  - hit = (fill_n == PAT_W) && (hist_n == pattern).
  - match<=hit.
  - Latency: match is high in the cycle after the edge that samples the completing bit, for exactly one cycle.
- Match in overlap mode (mode=1): hist and fill are kept, so the next match may reuse trailing bits.
- Match in non-overlap mode (mode=0): fill<=0, so the next match needs PAT_W fresh valid bits.
- x_valid=0: hist and fill hold; match<=0. Gaps of any length between valid bits are transparent.
- match_count:
  - Increments by 1 on each hit.
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr=1 sets the count to 0 and takes priority over a same-cycle hit; the match pulse still fires.
- armed = (state != UNARMED). It goes high in the cycle after load.
- Reset mid-stream: everything returns to reset values immediately. The pattern is lost and a new load is required.
- Reload while ARMED: a partial history is discarded. No match may be produced from bits sampled before the load.

Decomposition:
- Shared package seq_det_pkg: state encoding localparams (UNARMED=2'd0, FILL=2'd1, ARMED=2'd2) and the mode constants MODE_NONOVL=1'b0, MODE_OVL=1'b1.
- One sub-module: sat_counter, parameterised CNT_W, with inc, clr, async active-low rst, and count output. It is reusable elsewhere.
- The shift register, fill counter and FSM stay in seq_detector_param.

Test Plan:
1. Reset and unarmed:
   - Stimulus: assert rst=0 mid-operation; then release and drive x_valid=1 with random x for 20 cycles with no load.
   - Response: armed=0, match=0, match_count=0 throughout.
2. Overlap mode:
   - Stimulus: PAT_W=5; load pat_in=5'b10110, mode_in=1; stream 1,0,1,1,0,1,1,0.
   - Response: match pulses after bit 5 and after bit 8; match_count=2.
3. Non-overlap mode:
   - Stimulus: same stream with mode_in=0.
   - Response: a single match after bit 5; match_count=1.
   - Follow-up: bits 1,0,1,1,0 then produce a second match after 5 fresh bits.
4. Gaps and reload:
   - Stimulus: insert x_valid=0 gaps of 0–7 cycles between the bits of scenario 2.
   - Response: identical match count.
   - Stimulus: pulse load after bits 1,0,1,1, then send 0.
   - Response: no match.
5. Saturation and clear:
   - Stimulus: CNT_W=2, overlap mode, pattern 5'b00000, 12 zeros.
   - Response: match_count goes 1,2,3 and stays 3.
   - Stimulus: cnt_clr coincident with a hit.
   - Response: match_count=0 and match=1.
6. Load priority:
   - Stimulus: load and x_valid in the same cycle.
   - Response: the bit is ignored, fill=0, and the first match requires 5 subsequent valid bits.

Source files
------------

// File: rtl/seq_detector_param_pkg.sv
// Shared encodings for the runtime-programmable serial pattern detector.
// Mode constants select how trailing bits are reused after a match.
package seq_det_pkg;

  typedef enum logic [1:0] {
    UNARMED = 2'd0,
    FILL    = 2'd1,
    ARMED   = 2'd2
  } state_t;

  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

endpackage

// File: rtl/seq_detector_param_if.sv
// Control/stream/status bundle between a serial source and the pattern detector.
// The master modport drives stimulus; the slave modport is the detector side.
interface seq_detector_param_if #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8
);

  logic             i_load;
  logic [PAT_W-1:0] i_pat_in;
  logic             i_mode_in;
  logic             i_x;
  logic             i_x_valid;
  logic             i_cnt_clr;
  logic             o_armed;
  logic             o_match;
  logic [CNT_W-1:0] o_match_count;

  modport master (
    output i_load, i_pat_in, i_mode_in, i_x, i_x_valid, i_cnt_clr,
    input  o_armed, o_match, o_match_count
  );

  modport slave (
    input  i_load, i_pat_in, i_mode_in, i_x, i_x_valid, i_cnt_clr,
    output o_armed, o_match, o_match_count
  );

endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with runtime-loaded pattern and overlap mode.
// Emits a registered one-cycle match pulse and a saturating match count.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_detector_param_if.slave  bus
);

  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  state_t             r_state;
  state_t             w_state_n;
  logic [PAT_W-1:0]   r_pattern;
  logic [PAT_W-1:0]   w_pattern_n;
  logic               r_mode;
  logic               w_mode_n;
  logic [PAT_W-1:0]   r_hist;
  logic [PAT_W-1:0]   w_hist_n;
  logic [PAT_W-1:0]   w_hist_shift;
  logic [FILL_W-1:0]  r_fill;
  logic [FILL_W-1:0]  w_fill_n;
  logic [FILL_W-1:0]  w_fill_inc;
  logic               r_match;
  logic               w_sample;
  logic               w_hit;
  logic               w_cnt_clr;
  logic [CNT_W-1:0]   w_count;

  // A load in the same cycle swallows the serial bit, so it never samples.
  always_comb begin
    w_sample     = bus.i_x_valid && !bus.i_load && (r_state != UNARMED);
    w_hist_shift = {r_hist[PAT_W-2:0], bus.i_x};
    w_fill_inc   = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 1'b1;
    w_hit        = w_sample && (w_fill_inc == FILL_FULL) && (w_hist_shift == r_pattern);
  end

  always_comb begin
    w_state_n   = r_state;
    w_pattern_n = r_pattern;
    w_mode_n    = r_mode;
    w_hist_n    = r_hist;
    w_fill_n    = r_fill;

    if (bus.i_load) begin
      w_state_n   = FILL;
      w_pattern_n = bus.i_pat_in;
      w_mode_n    = bus.i_mode_in;
      w_hist_n    = '0;
      w_fill_n    = '0;
    end else if (w_sample) begin
      w_hist_n = w_hist_shift;
      // Non-overlap mode forces a full refill before the next match can fire.
      if (w_hit && (r_mode == MODE_NONOVL)) begin
        w_fill_n  = '0;
        w_state_n = FILL;
      end else begin
        w_fill_n  = w_fill_inc;
        w_state_n = (w_fill_inc == FILL_FULL) ? ARMED : FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= UNARMED;
      r_pattern <= '0;
      r_mode    <= MODE_NONOVL;
      r_hist    <= '0;
      r_fill    <= '0;
      r_match   <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_pattern <= w_pattern_n;
      r_mode    <= w_mode_n;
      r_hist    <= w_hist_n;
      r_fill    <= w_fill_n;
      r_match   <= w_hit;
    end
  end

  assign w_cnt_clr = bus.i_load || bus.i_cnt_clr;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_hit),
    .i_clr   (w_cnt_clr),
    .o_count (w_count)
  );

  assign bus.o_armed       = (r_state != UNARMED);
  assign bus.o_match       = r_match;
  assign bus.o_match_count = w_count;

endmodule
